// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM state encoding and
// access size codes as driven by the memory stage.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_bridge.sv
// Data-memory bridge: turns the memory stage's single-cycle load/store port
// into a req/addr_ok/data_ok bus transaction and stalls the pipeline until
// the access completes. Returned load data is held while the pipeline stays
// stalled for other reasons so every access is issued exactly once.
// Optional feature: define MEM_BRIDGE_ALIGN_CHECK_EN to flag misaligned
// half/word accesses on adel/ades instead of issuing them.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_en,
  input  logic [3:0]    mem_wen,
  input  logic [1:0]    mem_size,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_stall,
  input  logic          longest_stall,
  output logic          adel,
  output logic          ades,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata
);

  state_t        state;
  state_t        state_nxt;

  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [DW-1:0] rdata_q;

  logic          is_store;
  logic          fault;
  logic          issue;
  logic          resp_done;

`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
  // Half accesses need an even address, word accesses a 4-byte aligned one.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_HALF: bad = lo[0];
      SIZE_WORD: bad = (lo != 2'b00);
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

  assign fault = mem_en & misaligned(mem_size, mem_addr[1:0]);
`else
  assign fault = 1'b0;
`endif

  assign is_store = |mem_wen;

  // A new access is only launched from IDLE; gating with rst keeps the
  // combinational request path quiet while reset is held.
  assign issue     = rst & (state == ST_IDLE) & mem_en & ~fault;
  assign resp_done = (state == ST_RESP) & data_data_ok;

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the request fields on issue so they stay constant through REQ.
  always_ff @(posedge clk) begin
    if (issue) begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      wr_q    <= is_store;
      size_q  <= mem_size;
    end
  end

  // Hold the last response so the stage still sees it while stalled elsewhere.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (resp_done) begin
      rdata_q <= data_rdata;
    end
  end

  // Next-state logic and all bus / pipeline outputs.
  always_comb begin
    state_nxt  = state;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'b00;
    data_addr  = '0;
    data_wdata = '0;
    mem_stall  = 1'b0;
    adel       = 1'b0;
    ades       = 1'b0;
    mem_rdata  = rdata_q;

    case (state)
      ST_IDLE: begin
        if (issue) begin
          // Request goes out in the same cycle the access is first seen.
          data_req   = 1'b1;
          data_wr    = is_store;
          data_size  = mem_size;
          data_addr  = mem_addr;
          data_wdata = mem_wdata;
          mem_stall  = 1'b1;
          state_nxt  = data_addr_ok ? ST_RESP : ST_REQ;
        end
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
        adel = rst & fault & ~is_store;
        ades = rst & fault & is_store;
`endif
      end

      ST_REQ: begin
        // A data_ok here belongs to no request and is ignored.
        data_req   = 1'b1;
        data_wr    = wr_q;
        data_size  = size_q;
        data_addr  = addr_q;
        data_wdata = wdata_q;
        mem_stall  = 1'b1;
        if (data_addr_ok) begin
          state_nxt = ST_RESP;
        end
      end

      ST_RESP: begin
        if (data_data_ok) begin
          // Release the stall now; longest_stall then reflects only others.
          mem_rdata = data_rdata;
          state_nxt = longest_stall ? ST_DONE : ST_IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end

      ST_DONE: begin
        // Access finished; wait for the rest of the pipeline to move on.
        if (!longest_stall) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed testbench for mem_bridge: drives the core port and a scripted
// bus responder cycle by cycle and compares against hand-computed values.
module tb_mem_bridge;

  logic        clk;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        longest_stall;
  logic        adel;
  logic        ades;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        other_stall;

  int checks;
  int failures;
  int stall_cnt;
  int accept_cnt;

  assign longest_stall = mem_stall | other_stall;

  mem_bridge #(.AW(32), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_en       (mem_en),
    .mem_wen      (mem_wen),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_stall    (mem_stall),
    .longest_stall(longest_stall),
    .adel         (adel),
    .ades         (ades),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0; stall_cnt = 0; accept_cnt = 0;
    rst = 1'b0; mem_en = 1'b1; mem_wen = 4'h0; mem_size = 2'd2;
    mem_addr = 32'h10; mem_wdata = 32'h0; other_stall = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;

    // Reset state, with an access presented while reset is held
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   data_req,  0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_adel",  adel,      0);
    chk("rst_ades",  ades,      0);
    @(negedge clk);
    mem_en = 1'b0; rst = 1'b1;

    // Test 1: word load 0x10, zero-wait bus
    @(negedge clk);
    mem_en = 1'b1; mem_wen = 4'h0; mem_size = 2'd2; mem_addr = 32'h10;
    data_addr_ok = 1'b1;
    #1;
    chk("t1_req",   data_req,  1);
    chk("t1_stall", mem_stall, 1);
    chk("t1_addr",  data_addr, 32'h10);
    chk("t1_wr",    data_wr,   0);
    chk("t1_size",  data_size, 2);
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_req_resp", data_req,  0);
    chk("t1_stall_ok", mem_stall, 0);
    chk("t1_rdata",    mem_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    mem_en = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    #1;
    chk("t1_hold", mem_rdata, 32'hDEAD_BEEF);
    chk("t1_idle", data_req,  0);

    // Test 2: store, addr_ok after 3 cycles, data_ok 2 later
    stall_cnt = 0; accept_cnt = 0;
    @(negedge clk);
    mem_en = 1'b1; mem_wen = 4'hF; mem_size = 2'd2; mem_addr = 32'h20;
    mem_wdata = 32'h1234_5678;
    #1;
    chk("t2_req0", data_req, 1);
    chk("t2_wr0",  data_wr,  1);
    stall_cnt += int'(mem_stall); accept_cnt += int'(data_req & data_addr_ok);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      mem_addr = 32'hFFFF_FFF0; mem_wdata = 32'h0; mem_wen = 4'h0; mem_size = 2'd0;
      #1;
      chk("t2_req_hold",  data_req,   1);
      chk("t2_addr_hold", data_addr,  32'h20);
      chk("t2_wd_hold",   data_wdata, 32'h1234_5678);
      chk("t2_wr_hold",   data_wr,    1);
      chk("t2_sz_hold",   data_size,  2);
      stall_cnt += int'(mem_stall); accept_cnt += int'(data_req & data_addr_ok);
    end
    @(negedge clk);
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0000_0BAD;
    #1;
    chk("t2_req_acc",  data_req,  1);
    chk("t2_okign_rd", mem_rdata, 32'hDEAD_BEEF);
    stall_cnt += int'(mem_stall); accept_cnt += int'(data_req & data_addr_ok);
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    chk("t2_resp_wait", mem_stall, 1);
    chk("t2_resp_req",  data_req,  0);
    stall_cnt += int'(mem_stall); accept_cnt += int'(data_req & data_addr_ok);
    @(negedge clk);
    data_data_ok = 1'b1; data_rdata = 32'h0;
    #1;
    chk("t2_ack_stall", mem_stall, 0);
    stall_cnt += int'(mem_stall); accept_cnt += int'(data_req & data_addr_ok);
    @(negedge clk);
    mem_en = 1'b0; data_data_ok = 1'b0;
    #1;
    chk("t2_stall_cnt",  stall_cnt,  5);
    chk("t2_accept_cnt", accept_cnt, 1);
    chk("t2_idle_req",   data_req,   0);

    // Test 3: load completes while another source stalls for 4 more cycles
    @(negedge clk);
    mem_en = 1'b1; mem_wen = 4'h0; mem_size = 2'd2; mem_addr = 32'h40;
    data_addr_ok = 1'b1; other_stall = 1'b1;
    #1;
    chk("t3_req", data_req, 1);
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    #1;
    chk("t3_rdata", mem_rdata, 32'hCAFE_F00D);
    chk("t3_stall", mem_stall, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_data_ok = 1'b0; data_rdata = 32'h1111_1111;
      #1;
      chk("t3_done_req",   data_req,  0);
      chk("t3_done_stall", mem_stall, 0);
      chk("t3_done_rdata", mem_rdata, 32'hCAFE_F00D);
    end
    @(negedge clk);
    other_stall = 1'b0;
    #1;
    chk("t3_rel_req",   data_req,  0);
    chk("t3_rel_rdata", mem_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    mem_en = 1'b0;
    #1;
    chk("t3_after_req", data_req, 0);

    // Test 4: reset asserted in RESP, late data_ok discarded
    @(negedge clk);
    mem_en = 1'b1; mem_addr = 32'h80; data_addr_ok = 1'b1;
    #1;
    chk("t4_req", data_req, 1);
    @(negedge clk);
    data_addr_ok = 1'b0;
    #1;
    chk("t4_resp_stall", mem_stall, 1);
    rst = 1'b0;
    #1;
    chk("t4_rst_stall", mem_stall, 0);
    chk("t4_rst_rdata", mem_rdata, 0);
    chk("t4_rst_req",   data_req,  0);
    @(negedge clk);
    rst = 1'b1; mem_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
    #1;
    chk("t4_late_stall", mem_stall, 0);
    chk("t4_late_rdata", mem_rdata, 0);
    @(negedge clk);
    data_data_ok = 1'b0; data_rdata = 32'h0;
    #1;
    chk("t4_after_rdata", mem_rdata, 0);
    chk("t4_after_req",   data_req,  0);

    // Test 5: misaligned accesses
    @(negedge clk);
    mem_en = 1'b1; mem_wen = 4'h0; mem_size = 2'd2; mem_addr = 32'h2;
    #1;
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    chk("t5_adel",  adel,      1);
    chk("t5_ades0", ades,      0);
    chk("t5_req",   data_req,  0);
    chk("t5_stall", mem_stall, 0);
    @(negedge clk);
    mem_wen = 4'b0011; mem_size = 2'd1; mem_addr = 32'h1;
    #1;
    chk("t5_ades",  ades,      1);
    chk("t5_adel0", adel,      0);
    chk("t5_sreq",  data_req,  0);
    @(negedge clk);
    mem_en = 1'b0; mem_wen = 4'h0;
    #1;
    chk("t5_idle_req", data_req, 0);
`else
    chk("t5_adel_off", adel,      0);
    chk("t5_ades_off", ades,      0);
    chk("t5_req_pass", data_req,  1);
    chk("t5_addr_raw", data_addr, 32'h2);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_0077;
    #1;
    chk("t5_rdata", mem_rdata, 32'h0000_0077);
    @(negedge clk);
    mem_en = 1'b0; data_data_ok = 1'b0;
    #1;
    chk("t5_idle_req", data_req, 0);
`endif

    // Test 6: back-to-back loads to 0x0 and 0x4
    @(negedge clk);
    mem_en = 1'b1; mem_wen = 4'h0; mem_size = 2'd2; mem_addr = 32'h0;
    data_addr_ok = 1'b1;
    #1;
    chk("t6_req_a",  data_req,  1);
    chk("t6_addr_a", data_addr, 32'h0);
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hA0A0_A0A0;
    #1;
    chk("t6_rdata_a", mem_rdata, 32'hA0A0_A0A0);
    @(negedge clk);
    mem_addr = 32'h4; data_addr_ok = 1'b1; data_data_ok = 1'b0;
    #1;
    chk("t6_req_b",   data_req,  1);
    chk("t6_addr_b",  data_addr, 32'h4);
    chk("t6_stall_b", mem_stall, 1);
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hB1B1_B1B1;
    #1;
    chk("t6_rdata_b", mem_rdata, 32'hB1B1_B1B1);
    @(negedge clk);
    mem_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hEEEE_EEEE;
    #1;
    chk("t6_stray_ok", mem_rdata, 32'hB1B1_B1B1);
    @(negedge clk);
    data_data_ok = 1'b0; data_rdata = 32'h0;
    #1;
    chk("t6_final_rdata", mem_rdata, 32'hB1B1_B1B1);
    chk("t6_final_req",   data_req,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Data-memory bridge between the pipelined MIPS core's memory stage and an SRAM-like split-handshake bus. Converts the core's single-cycle load/store port (enable, write strobes, address, write data, read data) into a request/address-accept/data-return transaction and drives a stall back to the pipeline until the access completes. Holds returned load data stable while the rest of the pipeline remains stalled for unrelated reasons, so each memory-stage access is issued exactly once.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (fixed at 32 for this core)

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_en  in  1  memory-stage access valid (load or store)
- mem_wen  in  4  byte write strobes; nonzero = store
- mem_size  in  2  0 byte, 1 half, 2 word
- mem_addr  in  AW  byte address (aluoutM)
- mem_wdata  in  DW  store data, already lane-aligned (writedataM)
- mem_rdata  out  DW  load data to memory stage (readdataM)
- mem_stall  out  1  pipeline stall request from this bridge
- longest_stall  in  1  OR of all pipeline stalls, including mem_stall
- adel  out  1  misaligned load detected
- ades  out  1  misaligned store detected
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  copy of mem_size
- data_addr  out  AW  request address
- data_wdata  out  DW  write data
- data_addr_ok  in  1  request accepted this cycle
- data_data_ok  in  1  response (read data / write ack) this cycle
- data_rdata  in  DW  read data, valid with data_data_ok

## Operation
- FSM states: IDLE, REQ, RESP, DONE. Reset state IDLE.
- IDLE: if mem_en and no misalignment fault -> latch addr/wdata/wr/size, assert data_req combinationally this cycle; if data_addr_ok same cycle -> RESP else -> REQ.
- REQ: data_req = 1 with latched fields held constant; on data_addr_ok -> RESP.
- RESP: data_req = 0; on data_data_ok -> capture data_rdata into rdata register; if longest_stall would remain asserted by others (longest_stall & ~mem_stall-independent sources, i.e. longest_stall sampled with bridge releasing) -> DONE, else -> IDLE.
- DONE: no bus activity; mem_rdata from register; -> IDLE when longest_stall = 0.
- mem_stall = 1 in IDLE-with-new-access, REQ, RESP (until data_data_ok cycle inclusive = 0 on that cycle); 0 in DONE and idle.
- mem_rdata: data_rdata on the data_data_ok cycle, else rdata register.
- At most one outstanding transaction; data_data_ok outside RESP is ignored.
- Reset (asserted any state, including mid-transaction) forces IDLE, data_req = 0, mem_stall = 0, rdata register = 0, adel = ades = 0; a bus response arriving after reset is discarded.

## Timing
- Zero-wait bus (addr_ok with req, data_ok next cycle): 1 stall cycle per access.
- Stall cycles = cycles to addr_ok + cycles to data_ok.
- data_req asserted in the same cycle mem_en is first seen; fields never change while data_req = 1 and data_addr_ok = 0.
- Simultaneous data_addr_ok and data_data_ok in REQ: addr_ok honoured, data_ok ignored (belongs to no request).
- All outputs reset to 0.

## Configuration
- MEM_BRIDGE_ALIGN_CHECK_EN defined: half access with addr[0]=1 or word access with addr[1:0]!=0 asserts adel (load) or ades (store) combinationally in IDLE, no bus request issued, mem_stall = 0.
- Undefined: adel = ades = 0 constantly; low address bits passed through unchanged.

## Structure
- Shared package: state encoding (IDLE/REQ/RESP/DONE), size codes SIZE_BYTE/SIZE_HALF/SIZE_WORD.
- Single module; no sub-module needed. Alignment check is an inline combinational function guarded by the macro.

## Test plan
- Word load 0x0000_0010, zero-wait bus returning 0xDEAD_BEEF -> data_req 1 cycle, mem_stall 1 cycle, mem_rdata = 0xDEAD_BEEF.
- Store wen=4'b1111 addr 0x20 wdata 0x1234_5678, addr_ok delayed 3 cycles, data_ok 2 later -> fields constant during REQ, mem_stall 5 cycles, one request only.
- Load completing while longest_stall held 4 more cycles by another source -> DONE, mem_rdata held, no second data_req.
- Reset asserted in RESP, data_ok arrives next cycle -> stays IDLE, mem_rdata = 0, no stall.
- With MEM_BRIDGE_ALIGN_CHECK_EN: word load at 0x0000_0002 -> adel = 1, data_req = 0; half store at 0x1 -> ades = 1.
- Back-to-back loads to 0x0 and 0x4 -> two distinct transactions, correct data each.
